// File: rtl/ring_interlock_arbiter.sv
// Round-robin arbiter for the 8-station ring interlock: registered one-hot grants
// with a guard gap between owners, a maximum hold time and timeout lockout.
module ring_interlock_arbiter #(
  parameter int N_STN        = 8,
  parameter int GUARD_CYCLES = 2,
  parameter int MAX_HOLD     = 16,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_STN-1:0] i_req,
  output logic [N_STN-1:0] o_grant,
  output logic [2:0]       o_owner,
  output logic             o_busy,
  output logic             o_timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GUARD = 2'd2
  } state_t;

  state_t           state_r;
  logic [2:0]       ptr_r;
  logic [N_STN-1:0] lock_r;
  logic [CNT_W-1:0] hold_r;
  logic [CNT_W-1:0] guard_r;

  logic [N_STN-1:0] elig_s;
  logic [N_STN-1:0] lock_next_s;
  logic [3:0]       pick_s;
  logic [2:0]       next_ptr_s;
  logic             owner_req_s;
  logic             hold_max_s;

  // Scans from the highest ring offset down so the lowest offset from ptr wins.
  function automatic logic [3:0] ring_pick(input logic [N_STN-1:0] elig, input logic [2:0] ptr);
    logic [3:0] res;
    int         idx;
    res = 4'd0;
    for (int k = N_STN - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N_STN;
      if (elig[idx]) begin
        res = {1'b1, 3'(idx)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Arbitration candidates, release conditions and next lockout mask.
  always_comb begin
    elig_s      = i_req & ~lock_r;
    pick_s      = ring_pick(elig_s, ptr_r);
    owner_req_s = i_req[o_owner];
    hold_max_s  = (MAX_HOLD != 0) && (hold_r == CNT_W'(MAX_HOLD));
    next_ptr_s  = (o_owner == 3'(N_STN - 1)) ? 3'd0 : (o_owner + 3'd1);
    lock_next_s = lock_r & i_req;
    if ((state_r == GRANT) && owner_req_s && hold_max_s) begin
      lock_next_s[o_owner] = 1'b1;
    end else begin
      lock_next_s = lock_next_s;
    end
  end

  // Arbiter state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      ptr_r     <= 3'd0;
      lock_r    <= '0;
      hold_r    <= '0;
      guard_r   <= '0;
      o_grant   <= '0;
      o_owner   <= 3'd0;
      o_busy    <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      lock_r    <= lock_next_s;
      o_timeout <= 1'b0;
      case (state_r)
        IDLE: begin
          if (pick_s[3]) begin
            o_grant  <= N_STN'(1) << pick_s[2:0];
            o_owner  <= pick_s[2:0];
            o_busy   <= 1'b1;
            hold_r   <= CNT_W'(1);
            state_r  <= GRANT;
          end else begin
            o_grant  <= '0;
            o_busy   <= 1'b0;
          end
        end
        GRANT: begin
          // A dropped request takes precedence, so no timeout is flagged then.
          if (!owner_req_s || hold_max_s) begin
            o_grant   <= '0;
            o_busy    <= 1'b0;
            o_timeout <= owner_req_s;
            ptr_r     <= next_ptr_s;
            guard_r   <= CNT_W'(1);
            state_r   <= (GUARD_CYCLES == 0) ? IDLE : GUARD;
          end else if (hold_r != {CNT_W{1'b1}}) begin
            hold_r    <= hold_r + CNT_W'(1);
          end else begin
            hold_r    <= hold_r;
          end
        end
        GUARD: begin
          if (guard_r >= CNT_W'(GUARD_CYCLES)) begin
            state_r <= IDLE;
          end else begin
            guard_r <= guard_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          o_grant <= '0;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ring_interlock_arbiter.sv
// Directed and randomized bench for ring_interlock_arbiter, checked against a
// cycle-level reference model of the ring arbitration rules.
module tb_ring_interlock_arbiter;
  localparam int GUARD = 2;
  localparam int MAXH  = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req;
  logic [7:0] o_grant;
  logic [2:0] o_owner;
  logic       o_busy;
  logic       o_timeout;

  int total = 0;
  int bad   = 0;

  // reference model state
  int         m_owner, m_hold, m_gap, m_ptr, m_last;
  logic [7:0] m_lock;
  logic       m_tout;

  logic       prev_tout;
  logic [7:0] prev_grant;
  int         low_len;
  int         grant_log[$];
  int         gap_log[$];

  ring_interlock_arbiter dut (
    .clk(clk), .reset(reset), .i_req(req), .o_grant(o_grant),
    .o_owner(o_owner), .o_busy(o_busy), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [7:0] nl;
    bit         found;
    int         idx;
    if (reset) begin
      m_owner = -1; m_hold = 0; m_gap = 0; m_ptr = 0; m_last = 0;
      m_lock = 8'h00; m_tout = 1'b0;
    end else begin
      nl = m_lock & req;
      m_tout = 1'b0;
      if (m_owner >= 0) begin
        if (!req[m_owner]) begin
          m_ptr = (m_owner + 1) % 8; m_owner = -1; m_gap = GUARD;
        end else if (MAXH != 0 && m_hold == MAXH) begin
          nl[m_owner] = 1'b1; m_tout = 1'b1;
          m_ptr = (m_owner + 1) % 8; m_owner = -1; m_gap = GUARD;
        end else begin
          m_hold++;
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end else begin
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
          idx = (m_ptr + k) % 8;
          if (!found && req[idx] && !m_lock[idx]) begin
            found = 1'b1; m_owner = idx; m_last = idx; m_hold = 1;
          end
        end
      end
      m_lock = nl;
    end
  endtask

  task automatic tick();
    logic [7:0] exp_grant;
    @(posedge clk);
    model_step();
    #1;
    exp_grant = (m_owner >= 0) ? 8'(32'd1 << m_owner) : 8'h00;
    chk("grant", 32'(o_grant), 32'(exp_grant));
    chk("owner", 32'(o_owner), 32'(m_last));
    chk("busy", 32'(o_busy), 32'(m_owner >= 0));
    chk("timeout", 32'(o_timeout), 32'(m_tout));
    chk("onehot0", 32'($onehot0(o_grant)), 32'd1);
    chk("busy_or", 32'(o_busy), 32'(|o_grant));
    chk("tout_pair", 32'(prev_tout & o_timeout), 32'd0);
    prev_tout = o_timeout;
    if (o_grant != 8'h00 && prev_grant == 8'h00) begin
      grant_log.push_back(int'(o_owner));
      gap_log.push_back(low_len);
    end
    low_len = (o_grant == 8'h00) ? low_len + 1 : 0;
    prev_grant = o_grant;
  endtask

  task automatic wait_grant(input logic [7:0] g, input int budget, input string tag);
    int n;
    n = 0;
    while (o_grant !== g && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(o_grant), 32'(g));
  endtask

  task automatic do_reset();
    reset = 1'b1; req = 8'h00;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int n, len, c_cnt, a_cnt;
    reset = 1'b1; req = 8'hFF;
    m_owner = -1; m_hold = 0; m_gap = 0; m_ptr = 0; m_last = 0; m_lock = 8'h00; m_tout = 1'b0;
    prev_tout = 1'b0; prev_grant = 8'h00; low_len = 0;

    // 1: reset with all requests high, then A first
    tick();
    chk("t1_rst_grant", 32'(o_grant), 32'h0);
    tick();
    chk("t1_rst_busy", 32'(o_busy), 32'h0);
    reset = 1'b0;
    tick();
    chk("t1_first", 32'(o_grant), 32'h01);
    chk("t1_owner", 32'(o_owner), 32'h0);

    // 2: full rotation with 4-cycle holds
    grant_log.delete(); gap_log.delete();
    n = 0;
    while (grant_log.size() < 8 && n < 200) begin
      req = (m_owner >= 0 && m_hold == 4) ? ~(8'(32'd1 << m_owner)) : 8'hFF;
      tick();
      n++;
    end
    chk("t2_count", 32'(grant_log.size()), 32'd8);
    for (int i = 0; i < grant_log.size(); i++) begin
      chk("t2_order", 32'(grant_log[i]), 32'((i + 1) % 8));
      chk("t2_gap", 32'(gap_log[i]), 32'd3);
    end

    // 3: wrap from G to H before A, then pointer back at A
    do_reset();
    req = 8'h40;
    wait_grant(8'h40, 10, "t3_g");
    tick(); tick();
    req = 8'h81;
    tick();
    wait_grant(8'h80, 10, "t3_h_first");
    req = 8'h02;
    tick();
    req = 8'h03;
    wait_grant(8'h01, 10, "t3_a_next");

    // 4: max hold, timeout, lockout and re-eligibility of C
    do_reset();
    req = 8'h04;
    wait_grant(8'h04, 10, "t4_c");
    len = 1;
    while (o_grant == 8'h04 && len < 40) begin
      tick();
      if (o_grant == 8'h04) len++;
    end
    chk("t4_len", 32'(len), 32'd16);
    chk("t4_pulse", 32'(o_timeout), 32'd1);
    req = 8'h05;
    c_cnt = 0; a_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (o_grant == 8'h04) c_cnt++;
      if (o_grant == 8'h01) a_cnt++;
    end
    chk("t4_c_locked", 32'(c_cnt), 32'd0);
    chk("t4_a_served", 32'(a_cnt > 0), 32'd1);
    req = 8'h00;
    tick();
    req = 8'h04;
    wait_grant(8'h04, 10, "t4_c_again");

    // 5: reset mid-grant
    do_reset();
    req = 8'h08;
    wait_grant(8'h08, 10, "t5_d");
    tick();
    reset = 1'b1;
    tick();
    chk("t5_drop", 32'(o_grant), 32'h0);
    chk("t5_no_tout", 32'(o_timeout), 32'h0);
    reset = 1'b0; req = 8'h18;
    tick();
    chk("t5_d_again", 32'(o_grant), 32'h08);

    // 6: other requests toggling under E's grant
    do_reset();
    req = 8'h10;
    wait_grant(8'h10, 10, "t6_e");
    for (int i = 0; i < 12; i++) begin
      req = ((i % 2) != 0) ? 8'hFF : 8'h10;
      tick();
      chk("t6_stable", 32'(o_grant), 32'h10);
      chk("t6_owner", 32'(o_owner), 32'd4);
    end
    req = 8'hEF;
    tick();
    chk("t6_release", 32'(o_grant), 32'h0);

    // random persistent request patterns with occasional reset
    do_reset();
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(7) == 0) req[b] = ~req[b];
      end
      reset = ($urandom_range(149) == 0);
      tick();
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
